mips_cpu_mem_arbiter: RTL and testbench
=======================================

// Module: mips_cpu_mem_arbiter
// PURPOSE
//  Shares one Avalon-style memory port with waitrequest between the CPU's two requesters: instruction fetch (I) and data load/store (D).
//  Sits between the Harvard core's instr/data interfaces and the single system bus.
//  Serialises transactions, holds bus signals stable across wait states, and returns read data with a one-cycle ack pulse.
// PARAMETERS
//  ADDR_W  32  address width, all ports
//  DATA_W  32  data width, all ports; byteenable width = DATA_W/8
// PORTS
//  clk            in   1        clock; all logic on posedge
//  reset          in   1        asynchronous, active-low reset
//  i_req          in   1        fetch request; held with i_address until i_ack
//  i_address      in   ADDR_W   fetch byte address
//  i_readdata     out  DATA_W   fetched word; valid while i_ack=1
//  i_ack          out  1        one-cycle completion pulse, I port
//  d_req          in   1        data request; held with d_* fields until d_ack
//  d_write        in   1        1=store, 0=load
//  d_address      in   ADDR_W   data byte address
//  d_byteenable   in   DATA_W/8 store/load byte lanes
//  d_writedata    in   DATA_W   store data
//  d_readdata     out  DATA_W   load data; valid while d_ack=1
//  d_ack          out  1        one-cycle completion pulse, D port
//  m_address      out  ADDR_W   bus address
//  m_read         out  1        bus read strobe
//  m_write        out  1        bus write strobe
//  m_byteenable   out  DATA_W/8 bus byte lanes
//  m_writedata    out  DATA_W   bus write data
//  m_readdata     in   DATA_W   bus read data, valid when waitrequest=0
//  m_waitrequest  in   1        bus stall; strobes/fields held while 1
//  busy           out  1        1 whenever state != IDLE
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE; m_read=m_write=0; i_ack=d_ack=0; busy=0;
//   m_address, m_writedata, m_byteenable, i_readdata, d_readdata all 0; priority pointer -> D.
//  FSM states: IDLE, I_BUS, D_BUS. All outputs registered.
//  IDLE: evaluates eligible requests. A port is eligible if its req=1 and its own ack is 0 this cycle
//   (a req still high during its ack cycle is never re-granted).
//   Both eligible: D wins (fixed priority).
//   Grant I -> I_BUS: m_read=1, m_address=i_address, m_byteenable=all ones.
//   Grant D -> D_BUS: m_read=~d_write, m_write=d_write, address/byteenable/writedata copied from d_*.
//   D with d_byteenable=0: no bus cycle; d_ack=1 next cycle, d_readdata=0, stay IDLE.
//  I_BUS / D_BUS: all m_* held constant while m_waitrequest=1; no timeout.
//   Edge with m_waitrequest=0: drop m_read/m_write, capture m_readdata into owner's readdata
//   (stores capture 0), pulse owner's ack for exactly one cycle, go to IDLE.
//  Latency: req seen at edge N -> strobe high after N -> ack high after N+1 (zero wait states).
//   Each wait cycle adds 1. Back-to-back transactions are separated by one IDLE cycle.
//  Requester changes to req/fields while granted are ignored; the latched copy in m_* is used.
//  Non-owner readdata/ack stay unchanged/0. Address passed unmodified (no alignment check).
//  Reset mid-transaction: bus strobes drop immediately; pending transaction abandoned, no ack issued.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin on contention. After an I grant the pointer favours D,
//   after a D grant it favours I. A single eligible requester is always granted regardless of pointer.
//  MEM_ARB_RR_EN undefined: fixed priority D > I; pointer logic absent.
// TESTING
//  1. I only, i_address=32'hBFC00000, waitrequest=0, m_readdata=32'h24020005
//     -> m_read=1 one cycle later; i_ack pulse next cycle with i_readdata=32'h24020005.
//  2. D store, d_address=32'h00001000, d_writedata=32'hDEADBEEF, be=4'b1111, waitrequest held 1 for 3 cycles
//     -> m_write/m_* stable 4 cycles; single d_ack; m_write low after.
//  3. i_req and d_req raised same edge, fixed priority -> D load served first, then I.
//     With MEM_ARB_RR_EN and previous grant D -> I served first.
//  4. d_req with d_byteenable=4'b0000 -> no m_read/m_write ever; d_ack next cycle, d_readdata=0.
//  5. reset driven low during I_BUS with waitrequest=1 -> m_read, busy, i_ack all 0 asynchronously;
//     after release, IDLE and fresh i_req completes normally.
//  6. Requester holds i_req high through i_ack with d_req low -> exactly one extra read
//     (second fetch granted only after the ack cycle), never a double ack.

Source files
------------

// File: rtl/mips_cpu_mem_arbiter.sv
// Arbitrates the CPU fetch (I) and load/store (D) ports onto one waitrequest memory bus; MEM_ARB_RR_EN selects round-robin.
// Latency: request at edge N -> strobe after N -> ack after N+1, plus one cycle per wait state.
// Backpressure: m_waitrequest freezes all m_* fields; requesters hold req until their one-cycle ack.
module mips_cpu_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_address,
    output logic [DATA_W-1:0]     i_readdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_write,
    input  logic [ADDR_W-1:0]     d_address,
    input  logic [DATA_W/8-1:0]   d_byteenable,
    input  logic [DATA_W-1:0]     d_writedata,
    output logic [DATA_W-1:0]     d_readdata,
    output logic                  d_ack,
    output logic [ADDR_W-1:0]     m_address,
    output logic                  m_read,
    output logic                  m_write,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic [DATA_W-1:0]     m_writedata,
    input  logic [DATA_W-1:0]     m_readdata,
    input  logic                  m_waitrequest,
    output logic                  busy
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, I_BUS, D_BUS} state_t;

    state_t              state, state_nxt;
    logic                m_read_nxt, m_write_nxt, i_ack_nxt, d_ack_nxt;
    logic [ADDR_W-1:0]   m_address_nxt;
    logic [BE_W-1:0]     m_byteenable_nxt;
    logic [DATA_W-1:0]   m_writedata_nxt, i_readdata_nxt, d_readdata_nxt;
    logic                i_elig, d_elig, grant_d;

    // A request still high during its own ack cycle is the old one, not a new one.
    assign i_elig = i_req & ~i_ack;
    assign d_elig = d_req & ~d_ack;

`ifdef MEM_ARB_RR_EN
    logic prio_d, prio_d_nxt;
    assign grant_d = d_elig & (~i_elig | prio_d);
`else
    assign grant_d = d_elig;
`endif

    always_comb begin
        state_nxt        = state;
        m_read_nxt       = m_read;
        m_write_nxt      = m_write;
        m_address_nxt    = m_address;
        m_byteenable_nxt = m_byteenable;
        m_writedata_nxt  = m_writedata;
        i_readdata_nxt   = i_readdata;
        d_readdata_nxt   = d_readdata;
        i_ack_nxt        = 1'b0;
        d_ack_nxt        = 1'b0;
`ifdef MEM_ARB_RR_EN
        prio_d_nxt       = prio_d;
`endif
        case (state)
            IDLE: begin
                if (grant_d) begin
`ifdef MEM_ARB_RR_EN
                    prio_d_nxt = 1'b0;
`endif
                    // No byte lanes means nothing to do on the bus: complete locally.
                    if (d_byteenable == '0) begin
                        d_ack_nxt      = 1'b1;
                        d_readdata_nxt = '0;
                    end else begin
                        state_nxt        = D_BUS;
                        m_read_nxt       = ~d_write;
                        m_write_nxt      = d_write;
                        m_address_nxt    = d_address;
                        m_byteenable_nxt = d_byteenable;
                        m_writedata_nxt  = d_writedata;
                    end
                end else if (i_elig) begin
`ifdef MEM_ARB_RR_EN
                    prio_d_nxt = 1'b1;
`endif
                    state_nxt        = I_BUS;
                    m_read_nxt       = 1'b1;
                    m_address_nxt    = i_address;
                    m_byteenable_nxt = '1;
                end
            end
            I_BUS: begin
                if (!m_waitrequest) begin
                    state_nxt      = IDLE;
                    m_read_nxt     = 1'b0;
                    i_readdata_nxt = m_readdata;
                    i_ack_nxt      = 1'b1;
                end
            end
            D_BUS: begin
                if (!m_waitrequest) begin
                    state_nxt      = IDLE;
                    m_read_nxt     = 1'b0;
                    m_write_nxt    = 1'b0;
                    d_readdata_nxt = m_write ? '0 : m_readdata;
                    d_ack_nxt      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_byteenable <= '0;
            m_writedata  <= '0;
            i_readdata   <= '0;
            d_readdata   <= '0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            busy         <= 1'b0;
`ifdef MEM_ARB_RR_EN
            prio_d       <= 1'b1;
`endif
        end else begin
            state        <= state_nxt;
            m_read       <= m_read_nxt;
            m_write      <= m_write_nxt;
            m_address    <= m_address_nxt;
            m_byteenable <= m_byteenable_nxt;
            m_writedata  <= m_writedata_nxt;
            i_readdata   <= i_readdata_nxt;
            d_readdata   <= d_readdata_nxt;
            i_ack        <= i_ack_nxt;
            d_ack        <= d_ack_nxt;
            busy         <= (state_nxt != IDLE);
`ifdef MEM_ARB_RR_EN
            prio_d       <= prio_d_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Bench for mips_cpu_mem_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_mips_cpu_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_write = 1'b0, m_waitrequest = 1'b0;
    logic [31:0] i_address = '0, d_address = '0, d_writedata = '0, m_readdata = '0;
    logic [3:0]  d_byteenable = '0;
    logic [31:0] i_readdata, d_readdata, m_address, m_writedata;
    logic        i_ack, d_ack, m_read, m_write, busy;
    logic [3:0]  m_byteenable;

    int checks = 0;
    int failures = 0;

    mips_cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_address(i_address), .i_readdata(i_readdata), .i_ack(i_ack),
        .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_byteenable(d_byteenable),
        .d_writedata(d_writedata), .d_readdata(d_readdata), .d_ack(d_ack),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_byteenable(m_byteenable),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus (0 none, 1 fetch, 2 data) plus the transaction it latched.
    int          owner = 0;
    logic [31:0] e_addr = '0, e_wd = '0, e_ird = '0, e_drd = '0;
    logic [3:0]  e_be = '0;
    logic        e_wr = 1'b0, e_iack = 1'b0, e_dack = 1'b0;
`ifdef MEM_ARB_RR_EN
    bit          favour_d = 1'b1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = 0; e_addr = '0; e_wd = '0; e_ird = '0; e_drd = '0; e_be = '0;
        e_wr = 1'b0; e_iack = 1'b0; e_dack = 1'b0;
`ifdef MEM_ARB_RR_EN
        favour_d = 1'b1;
`endif
    endtask

    task automatic model_step();
        bit ie, de;
        int pick;
        ie = i_req && !e_iack;
        de = d_req && !e_dack;
        e_iack = 1'b0;
        e_dack = 1'b0;
        if (owner == 0) begin
            pick = 0;
            if (ie && de) begin
`ifdef MEM_ARB_RR_EN
                pick = favour_d ? 2 : 1;
`else
                pick = 2;
`endif
            end else if (de) pick = 2;
            else if (ie) pick = 1;
            if (pick == 2) begin
`ifdef MEM_ARB_RR_EN
                favour_d = 1'b0;
`endif
                if (d_byteenable == 4'b0000) begin
                    e_dack = 1'b1;
                    e_drd  = '0;
                end else begin
                    owner = 2; e_wr = d_write; e_addr = d_address; e_be = d_byteenable; e_wd = d_writedata;
                end
            end else if (pick == 1) begin
`ifdef MEM_ARB_RR_EN
                favour_d = 1'b1;
`endif
                owner = 1; e_addr = i_address; e_be = 4'hF;
            end
        end else if (!m_waitrequest) begin
            if (owner == 1) begin
                e_ird = m_readdata; e_iack = 1'b1;
            end else begin
                e_drd = e_wr ? 32'h0 : m_readdata; e_dack = 1'b1;
            end
            owner = 0;
        end
    endtask

    task automatic compare_all();
        check("m_read",       m_read,       (owner == 1) || (owner == 2 && !e_wr));
        check("m_write",      m_write,      (owner == 2 && e_wr));
        check("busy",         busy,         owner != 0);
        check("m_address",    m_address,    e_addr);
        check("m_byteenable", m_byteenable, e_be);
        check("m_writedata",  m_writedata,  e_wd);
        check("i_ack",        i_ack,        e_iack);
        check("d_ack",        d_ack,        e_dack);
        check("i_readdata",   i_readdata,   e_ird);
        check("d_readdata",   d_readdata,   e_drd);
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic cycle();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        bit first_d;
        logic [31:0] ia, da;

        // Reset state
        reset = 1'b0;
        idle(2);
        check("rst_m_read", m_read, 0);
        check("rst_busy", busy, 0);
        check("rst_m_address", m_address, 0);
        reset = 1'b1;
        idle(1);

        // 1: single fetch, zero wait states
        i_req = 1; i_address = 32'hBFC00000; m_waitrequest = 0; m_readdata = 32'h24020005;
        cycle();
        check("t1_m_read", m_read, 1);
        check("t1_m_address", m_address, 32'hBFC00000);
        check("t1_be", m_byteenable, 4'hF);
        cycle();
        check("t1_i_ack", i_ack, 1);
        check("t1_i_readdata", i_readdata, 32'h24020005);
        check("t1_m_read_low", m_read, 0);
        i_req = 0;
        cycle();
        check("t1_i_ack_once", i_ack, 0);
        idle(1);

        // 2: store stalled by three wait states
        d_req = 1; d_write = 1; d_address = 32'h00001000; d_writedata = 32'hDEADBEEF;
        d_byteenable = 4'hF; m_waitrequest = 1;
        cycle();
        check("t2_m_write", m_write, 1);
        for (int k = 0; k < 3; k++) begin
            d_writedata = 32'h12345678 + k;
            cycle();
            check("t2_m_write_held", m_write, 1);
            check("t2_wd_held", m_writedata, 32'hDEADBEEF);
            check("t2_addr_held", m_address, 32'h00001000);
            check("t2_no_ack", d_ack, 0);
        end
        m_waitrequest = 0;
        cycle();
        check("t2_d_ack", d_ack, 1);
        check("t2_m_write_low", m_write, 0);
        check("t2_d_readdata", d_readdata, 0);
        d_req = 0; d_write = 0;
        cycle();
        check("t2_d_ack_once", d_ack, 0);
        idle(1);

`ifdef MEM_ARB_RR_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        // 3: simultaneous requests
        ia = 32'h00400000; da = 32'h00002000;
        i_req = 1; i_address = ia; d_req = 1; d_write = 0; d_address = da; d_byteenable = 4'hF;
        m_readdata = 32'h11111111;
        cycle();
        check("t3_first_addr", m_address, first_d ? da : ia);
        check("t3_first_read", m_read, 1);
        cycle();
        check("t3_first_ack", first_d ? d_ack : i_ack, 1);
        check("t3_first_data", first_d ? d_readdata : i_readdata, 32'h11111111);
        if (first_d) d_req = 0; else i_req = 0;
        m_readdata = 32'h22222222;
        cycle();
        check("t3_second_addr", m_address, first_d ? ia : da);
        cycle();
        check("t3_second_ack", first_d ? i_ack : d_ack, 1);
        check("t3_second_data", first_d ? i_readdata : d_readdata, 32'h22222222);
        i_req = 0; d_req = 0;
        idle(2);

        // 4: data request with no byte lanes completes without a bus cycle
        d_req = 1; d_write = 0; d_address = 32'h00003000; d_byteenable = 4'h0; m_readdata = 32'h33333333;
        cycle();
        check("t4_d_ack", d_ack, 1);
        check("t4_d_readdata", d_readdata, 0);
        check("t4_no_read", m_read, 0);
        check("t4_not_busy", busy, 0);
        d_req = 0;
        cycle();
        check("t4_d_ack_once", d_ack, 0);
        idle(1);

        // 5: asynchronous reset in the middle of a stalled fetch
        i_req = 1; i_address = 32'h00000040; m_waitrequest = 1;
        cycle();
        check("t5_m_read", m_read, 1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_m_read", m_read, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_i_ack", i_ack, 0);
        model_reset();
        cycle();
        reset = 1'b1; m_waitrequest = 0; m_readdata = 32'h44444444;
        cycle();
        check("t5_regrant", m_address, 32'h00000040);
        cycle();
        check("t5_i_ack", i_ack, 1);
        check("t5_i_readdata", i_readdata, 32'h44444444);
        i_req = 0;
        idle(2);

        // 6: fetch request held through its ack
        i_req = 1; i_address = 32'h00000080; m_readdata = 32'h55555555;
        cycle();
        cycle();
        check("t6_ack1", i_ack, 1);
        cycle();
        check("t6_gap_ack", i_ack, 0);
        check("t6_gap_read", m_read, 0);
        cycle();
        check("t6_second_read", m_read, 1);
        i_req = 0;
        cycle();
        check("t6_ack2", i_ack, 1);
        cycle();
        check("t6_no_third", m_read, 0);
        check("t6_ack_done", i_ack, 0);
        idle(1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            m_waitrequest = ($urandom_range(0, 2) == 0);
            m_readdata = $urandom;
            if (e_iack) i_req = ($urandom_range(0, 3) == 0);
            else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_address = $urandom;
            end
            if (e_dack) d_req = ($urandom_range(0, 3) == 0);
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_write = 1'($urandom_range(0, 1)); d_address = $urandom;
                d_byteenable = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                d_writedata = $urandom;
            end
            if (owner == 2) begin
                d_writedata = $urandom; d_address = $urandom;
            end
            if (owner == 1) i_address = $urandom;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
